// File: rtl/phy_rx_lane_merge.sv
// Two-lane RX merger: rebuilds 32-bit words from lane 0/1 byte pairs, tracks link activity.
// Latency: data_out/valid_out registered one cycle after the low-half byte sample.
// Backpressure: none; lanes are sampled every clk_4f cycle and words are never stalled.
module phy_rx_lane_merge #(
  parameter int IDLE_LIMIT = 4
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [7:0]  data_in_0,
  input  logic        valid_in0,
  input  logic [7:0]  data_in_1,
  input  logic        valid_in1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        err
);

  // One half-word as it arrives across the two lanes in a single cycle.
  typedef struct packed {
    logic [7:0] lane0_dat;
    logic [7:0] lane1_dat;
  } half_t;

  typedef enum logic {
    ST_HI = 1'b0,
    ST_LO = 1'b1
  } state_t;

  localparam logic [3:0] IDLE_LIM = 4'(IDLE_LIMIT);

  state_t     state;
  half_t      hi_half;
  half_t      cur_half;
  logic [3:0] idle_cnt;
  logic [3:0] idle_cnt_nxt;
  logic       both_vld;
  logic       idle_cyc;
  logic       lane_mis;
  logic       idle_tick;

  // Classify the current cycle and compute the next idle count.
  always_comb begin
    cur_half.lane0_dat = data_in_0;
    cur_half.lane1_dat = data_in_1;
    both_vld     = valid_in0 & valid_in1;
    idle_cyc     = ~valid_in0 & ~valid_in1;
    lane_mis     = valid_in0 ^ valid_in1;
    // Count only while the link is up; once active drops the count freezes.
    idle_tick    = idle_cyc & active & (idle_cnt != 4'hF);
    idle_cnt_nxt = idle_cnt + 4'd1;
  end

  // Idle counter: cleared by any fully valid cycle, saturating, frozen after timeout.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      idle_cnt <= 4'd0;
    end else if (both_vld) begin
      idle_cnt <= 4'd0;
    end else if (idle_tick) begin
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Word assembly FSM with registered outputs; a mismatch or idle always restarts at HI.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state     <= ST_HI;
      hi_half   <= '0;
      data_out  <= 32'd0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      err       <= 1'b0;
      if (lane_mis) begin
        // Lanes disagree: flag it and drop whatever half was held.
        err     <= 1'b1;
        hi_half <= '0;
        state   <= ST_HI;
      end else if (both_vld) begin
        unique case (state)
          ST_HI: begin
            hi_half <= cur_half;
            state   <= ST_LO;
          end
          ST_LO: begin
            data_out  <= {hi_half, cur_half};
            valid_out <= 1'b1;
            active    <= 1'b1;
            state     <= ST_HI;
          end
          default: state <= ST_HI;
        endcase
      end else begin
        // Idle cycle: a held high half cannot be completed any more.
        hi_half <= '0;
        state   <= ST_HI;
        if (idle_tick && (idle_cnt_nxt == IDLE_LIM)) begin
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_lane_merge.sv
// Directed bench for phy_rx_lane_merge with IDLE_LIMIT = 4.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected words are hand-assembled as {lane0 first, lane1 first, lane0 second, lane1 second}.
module tb_phy_rx_lane_merge;

  logic        clk_4f;
  logic        reset;
  logic [7:0]  data_in_0;
  logic        valid_in0;
  logic [7:0]  data_in_1;
  logic        valid_in1;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic        err;

  int checks;
  int errors;

  phy_rx_lane_merge #(.IDLE_LIMIT(4)) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .data_in_0 (data_in_0),
    .valid_in0 (valid_in0),
    .data_in_1 (data_in_1),
    .valid_in1 (valid_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .err       (err)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // Drive one cycle of lane inputs, then wait until just after the sampling edge.
  task automatic step(input logic v0, input logic [7:0] d0,
                      input logic v1, input logic [7:0] d1);
    @(negedge clk_4f);
    valid_in0 = v0;
    data_in_0 = d0;
    valid_in1 = v1;
    data_in_1 = d1;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [31:0] d, input logic vo,
                          input logic act, input logic e);
    chk32({tag, ".data_out"}, data_out, d);
    chk1({tag, ".valid_out"}, valid_out, vo);
    chk1({tag, ".active"}, active, act);
    chk1({tag, ".err"}, err, e);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    data_in_0 = 8'h00;
    data_in_1 = 8'h00;

    // Reset for two cycles with random lane activity.
    for (int i = 0; i < 2; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      chk_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    idle();
    chk_outs("post_reset_idle", 32'h0, 1'b0, 1'b0, 1'b0);

    // Single word 0xFFFFEEEE.
    step(1'b1, 8'hFF, 1'b1, 8'hFF);
    chk_outs("single_hi", 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 8'hEE);
    chk_outs("single_lo", 32'hFFFFEEEE, 1'b1, 1'b1, 1'b0);
    idle();
    chk_outs("single_after", 32'hFFFFEEEE, 1'b0, 1'b1, 1'b0);

    // Back-to-back words 0xAAAA1234, 0x12345678.
    step(1'b1, 8'hAA, 1'b1, 8'hAA);
    chk1("b2b_c1.valid_out", valid_out, 1'b0);
    step(1'b1, 8'h12, 1'b1, 8'h34);
    chk_outs("b2b_c2", 32'hAAAA1234, 1'b1, 1'b1, 1'b0);
    step(1'b1, 8'h12, 1'b1, 8'h34);
    chk_outs("b2b_c3", 32'hAAAA1234, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h56, 1'b1, 8'h78);
    chk_outs("b2b_c4", 32'h12345678, 1'b1, 1'b1, 1'b0);

    // Gap mid-word: CC/EE high half is abandoned.
    step(1'b1, 8'hCC, 1'b1, 8'hEE);
    chk1("gap_hi.valid_out", valid_out, 1'b0);
    idle();
    chk_outs("gap_idle", 32'h12345678, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 8'hBB);
    chk_outs("gap_new_hi", 32'h12345678, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 8'hAA);
    chk_outs("gap_word", 32'hBBBBAAAA, 1'b1, 1'b1, 1'b0);

    // Lane mismatch while holding 0x1234.
    step(1'b1, 8'h12, 1'b1, 8'h34);
    chk1("mis_hi.valid_out", valid_out, 1'b0);
    step(1'b1, 8'h55, 1'b0, 8'h66);
    chk_outs("mis_cycle", 32'hBBBBAAAA, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h11, 1'b1, 8'h22);
    chk_outs("mis_new_hi", 32'hBBBBAAAA, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b1, 8'h44);
    chk_outs("mis_word", 32'h11223344, 1'b1, 1'b1, 1'b0);

    // Three idle cycles then a word: active stays up.
    for (int i = 0; i < 3; i++) begin
      idle();
      chk1("idle3.active", active, 1'b1);
    end
    step(1'b1, 8'h01, 1'b1, 8'h02);
    chk1("idle3_hi.active", active, 1'b1);
    step(1'b1, 8'h03, 1'b1, 8'h04);
    chk_outs("idle3_word", 32'h01020304, 1'b1, 1'b1, 1'b0);

    // Four idle cycles: active drops on the fourth.
    for (int i = 0; i < 3; i++) begin
      idle();
      chk1("idle4_pre.active", active, 1'b1);
    end
    idle();
    chk1("idle4_drop.active", active, 1'b0);
    idle();
    chk1("idle4_hold.active", active, 1'b0);

    // A lone high half followed by idle must not raise active.
    step(1'b1, 8'h77, 1'b1, 8'h77);
    chk1("lone_hi.active", active, 1'b0);
    idle();
    chk_outs("lone_idle", 32'h01020304, 1'b0, 1'b0, 1'b0);

    // Next completed word raises active again.
    step(1'b1, 8'h05, 1'b1, 8'h06);
    chk1("reup_hi.active", active, 1'b0);
    step(1'b1, 8'h07, 1'b1, 8'h08);
    chk_outs("reup_word", 32'h05060708, 1'b1, 1'b1, 1'b0);

    // Reset mid-word discards the held half.
    step(1'b1, 8'h9A, 1'b1, 8'h9B);
    chk1("rst_mid_hi.valid_out", valid_out, 1'b0);
    reset = 1'b1;
    step(1'b1, 8'hC1, 1'b1, 8'hC2);
    chk_outs("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 8'hD1, 1'b1, 8'hD2);
    chk_outs("rst_after_hi", 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE1, 1'b1, 8'hE2);
    chk_outs("rst_after_word", 32'hD1D2E1E2, 1'b1, 1'b1, 1'b0);
    idle();
    chk1("final.valid_out", valid_out, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_rx_lane_merge.md
# phy_rx_lane_merge

Receive-side lane merger for the two-lane PCIe-style physical layer: recombines the byte streams on lane 0 and lane 1 into 32-bit words for the upper layer. It is the counterpart of the TX lane splitter and sits between the per-lane RX byte paths and the link-layer interface. It runs entirely in the `clk_4f` domain and tracks link activity with an idle-timeout counter.

## Interface
Parameters:
- `IDLE_LIMIT`, default 4: consecutive idle cycles (both lanes invalid) that deassert `active`; legal range 1–15.

Ports:
- `clk_4f`  input  1  byte clock; all logic on its rising edge
- `reset`  input  1  synchronous, active-high reset
- `data_in_0`  input  8  lane 0 byte
- `valid_in0`  input  1  lane 0 byte valid
- `data_in_1`  input  8  lane 1 byte
- `valid_in1`  input  1  lane 1 byte valid
- `data_out`  output  32  reassembled word
- `valid_out`  output  1  one-cycle pulse; `data_out` holds a new word
- `active`  output  1  link carrying data
- `err`  output  1  one-cycle pulse on lane valid mismatch

## Operation
- Byte mapping for word W = {B3,B2,B1,B0}: lane 0 carries B3 then B1; lane 1 carries B2 then B0.
  - The high half {B3,B2} arrives first; the low half {B1,B0} arrives on the next valid cycle.
- The FSM has two states:
  - **HI**: expecting the high half.
    - Both lanes valid: store {data_in_0, data_in_1} as the high half and go to LO.
  - **LO**: holding the high half.
    - Both lanes valid: load `data_out` = {hi0, hi1, data_in_0, data_in_1}, pulse `valid_out`, set `active`, and go to HI.
- Idle cycle (both lanes invalid):
  - In LO, discard the held half and go to HI; no `valid_out`.
  - In HI, stay in HI.
- Lane mismatch (`valid_in0` != `valid_in1`), in either state:
  - Pulse `err`, discard any held half, and go to HI.
  - The mismatch cycle does not count as idle and does not clear the idle counter.
- Idle counter (4 bits, saturating):
  - Increments on each idle cycle while `active` = 1.
  - Clears on any cycle with both lanes valid.
  - On the cycle it reaches `IDLE_LIMIT`, clear `active` and hold the count until the next valid cycle.
- `active` sets only on word completion. A lone high half followed by idle never asserts it.
- `data_out` holds the last completed word until the next completion.
- Reset has priority over every other event:
  - outputs: `data_out` = 0, `valid_out` = 0, `active` = 0, `err` = 0
  - internal: FSM = HI, held half = 0, idle counter = 0
  - Reset mid-word discards the partial word.

## Timing
- High half sampled on edge k, low half on edge k+1. `data_out`/`valid_out` update on edge k+1 (registered), so they are visible for the cycle after k+1.
  - Latency: one cycle from the last byte sample.
- Back-to-back words with lanes continuously valid give `valid_out` on every second cycle, since peak throughput is one word per 2 cycles.
- `err` is registered: it is high for exactly one cycle, following the sampling edge of the mismatch.
- `active` falls on the edge that samples the `IDLE_LIMIT`-th consecutive idle cycle.
  - With default 4: three idle cycles followed by a valid cycle keep `active` high.
- `valid_out` and `err` are never high in the same cycle.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random lane inputs → all outputs 0. After release, no `valid_out` until a full two-cycle word arrives.
- **Single word:** lane 0 = FF,EE; lane 1 = FF,EE on consecutive valid cycles → `data_out` = 0xFFFFEEEE. `valid_out` pulses once, then `active` = 1.
- **Back-to-back words:** send 0xAAAA1234 then 0x12345678 with no gap → `valid_out` is high on cycles 2 and 4, with `data_out` = 0xAAAA1234 then 0x12345678.
- **Gap mid-word:** high half of 0xCCEEEEEE (CC/EE), then one idle cycle, then full 0xBBBBAAAA → no word from CC/EE and no `err`. `data_out` = 0xBBBBAAAA.
- **Lane mismatch:** in LO holding 0x1234, drive `valid_in0` = 1 and `valid_in1` = 0 → `err` pulses one cycle, the held half is discarded, and the next full word is reassembled correctly.
- **Idle timeout (`IDLE_LIMIT` = 4):**
  - After one word, give 3 idle cycles and then a word → `active` stays 1.
  - Then give 4 idle cycles → `active` drops on the 4th idle edge and rises again only after the next completed word.
- **Reset mid-word:** assert `reset` while in LO → no `valid_out`, and the next word decodes cleanly.
